// File: rtl/fm_audio_decimate_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_audio_decimate_if                                                 |
// | AXI-Stream bundle (tvalid/tready/tdata/tlast/tstrb) with modports.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fm_audio_decimate_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      tvalid;
  logic                      tready;
  logic [DATA_WIDTH-1:0]     tdata;
  logic                      tlast;
  logic [DATA_WIDTH/8-1:0]   tstrb;

  modport master (output tvalid, output tdata, output tlast, output tstrb, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tstrb, output tready);
endinterface
`default_nettype wire

// File: rtl/fm_audio_decimate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fm_audio_decimate                                                    |
// | Boxcar decimator (mean of 2^DECIM_LOG2 samples) for FM audio, with   |
// | optional single-pole de-emphasis selected by macro FM_DEEMPH_EN.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fm_audio_decimate #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int DECIM_LOG2             = 3,
  parameter int DEEMPH_SHIFT           = 4
) (
  input  wire logic            s00_axis_aclk,
  input  wire logic            s00_axis_areset,
  fm_audio_decimate_if.slave   s00_axis,
  fm_audio_decimate_if.master  m00_axis
);

  localparam int c_acc_w = 16 + DECIM_LOG2;

  logic signed [c_acc_w-1:0]    r_acc;
  logic        [DECIM_LOG2-1:0] r_cnt;
  logic                         r_tvalid;
  logic                         r_tlast;
  logic signed [15:0]           r_tdata;

  logic signed [15:0]           w_x;
  logic signed [c_acc_w-1:0]    w_sum;
  logic signed [c_acc_w-1:0]    w_shift;
  logic signed [15:0]           w_mean;
  logic signed [15:0]           w_out;
  logic                         w_ready;
  logic                         w_beat;
  logic                         w_dump;
  logic                         w_unused_in;

  assign w_x     = s00_axis.tdata[15:0];
  assign w_sum   = r_acc + {{DECIM_LOG2{w_x[15]}}, w_x};
  // The sum of 2^DECIM_LOG2 16-bit samples fits c_acc_w bits, so the mean fits 16.
  assign w_shift = w_sum >>> DECIM_LOG2;
  assign w_mean  = w_shift[15:0];

  assign w_ready = !r_tvalid || m00_axis.tready;
  assign w_beat  = s00_axis.tvalid && w_ready;
  assign w_dump  = w_beat && ((r_cnt == {DECIM_LOG2{1'b1}}) || s00_axis.tlast);

  assign w_unused_in = ^{s00_axis.tstrb, s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1:16]};

`ifdef FM_DEEMPH_EN
  logic signed [15:0] r_y;
  logic signed [16:0] w_d;
  logic signed [16:0] w_d_sh;
  logic signed [16:0] w_y_sum;

  assign w_d     = {w_mean[15], w_mean} - {r_y[15], r_y};
  assign w_d_sh  = w_d >>> DEEMPH_SHIFT;
  assign w_y_sum = {r_y[15], r_y} + w_d_sh;
  assign w_out   = w_y_sum[15:0];

  // Filter state persists across packets; only reset clears it.
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_y <= '0;
    end else if (w_dump) begin
      r_y <= w_out;
    end
  end
`else
  localparam int c_unused_shift = DEEMPH_SHIFT;
  assign w_out = w_mean;
`endif

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_beat) begin
        if (w_dump) begin
          r_acc    <= '0;
          r_cnt    <= '0;
          r_tdata  <= w_out;
          r_tlast  <= s00_axis.tlast;
          r_tvalid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + DECIM_LOG2'(1);
        end
      end
      if (r_tvalid && m00_axis.tready && !w_dump) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign s00_axis.tready = w_ready;
  assign m00_axis.tvalid = r_tvalid;
  assign m00_axis.tlast  = r_tlast;
  assign m00_axis.tstrb  = '1;

  generate
    if (C_M00_AXIS_TDATA_WIDTH > 16) begin : g_sext
      assign m00_axis.tdata = {{(C_M00_AXIS_TDATA_WIDTH-16){r_tdata[15]}}, r_tdata};
    end else begin : g_narrow
      assign m00_axis.tdata = r_tdata;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fm_audio_decimate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fm_audio_decimate                                                 |
// | Table-driven plus scoreboard bench for fm_audio_decimate.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fm_audio_decimate;

  localparam int DECIM_LOG2   = 3;
  localparam int DEEMPH_SHIFT = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int first;
    int rest;
    int n;
    bit last_on_final;
    int mean;
    bit exp_last;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_out;
  int   tb_y;
  exp_t sb[$];

  fm_audio_decimate_if #(.DATA_WIDTH(32)) s_if ();
  fm_audio_decimate_if #(.DATA_WIDTH(32)) m_if ();

  fm_audio_decimate #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .DECIM_LOG2(DECIM_LOG2),
    .DEEMPH_SHIFT(DEEMPH_SHIFT)
  ) dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .s00_axis       (s_if),
    .m00_axis       (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Expected output for a window mean, through the de-emphasis model when built in.
  task automatic push_exp(input int mean, input bit last, output logic [31:0] val);
    int v;
`ifdef FM_DEEMPH_EN
    int d;
    d    = mean - tb_y;
    tb_y = tb_y + (d >>> DEEMPH_SHIFT);
    v    = tb_y;
`else
    v    = mean;
`endif
    val = v;
    sb.push_back('{data: val, last: last});
  endtask

  // Holds the beat until it is accepted; returns 1 time unit after the accepting edge.
  task automatic send(input int v, input bit last);
    bit acc;
    int guard;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'(v);
    s_if.tlast  = last;
    guard = 0;
    forever begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got tready=0, expected tready=1");
        break;
      end
    end
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && m_if.tvalid && m_if.tready) begin
      exp_t e;
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%08h, expected no beat", m_if.tdata);
      end else begin
        e = sb.pop_front();
        check("out_data", m_if.tdata, e.data);
        check("out_last", {31'b0, m_if.tlast}, {31'b0, e.last});
      end
    end
  end

  initial begin
    vec_t        vecs[9];
    logic [31:0] ev;
    logic [31:0] bp_first;
    int          out_before;

    vecs[0] = '{first: -3,     rest: -3,     n: 8, last_on_final: 0, mean: -3,     exp_last: 0};
    vecs[1] = '{first: -1,     rest: 0,      n: 8, last_on_final: 0, mean: -1,     exp_last: 0};
    vecs[2] = '{first: 32767,  rest: 32767,  n: 8, last_on_final: 0, mean: 32767,  exp_last: 0};
    vecs[3] = '{first: -32768, rest: -32768, n: 8, last_on_final: 0, mean: -32768, exp_last: 0};
    vecs[4] = '{first: 80,     rest: 80,     n: 3, last_on_final: 1, mean: 30,     exp_last: 1};
    vecs[5] = '{first: 10,     rest: 10,     n: 8, last_on_final: 0, mean: 10,     exp_last: 0};
    vecs[6] = '{first: 20,     rest: 20,     n: 8, last_on_final: 1, mean: 20,     exp_last: 1};
    vecs[7] = '{first: -8,     rest: 0,      n: 1, last_on_final: 1, mean: -1,     exp_last: 1};
    vecs[8] = '{first: 7,      rest: 9,      n: 8, last_on_final: 0, mean: 8,      exp_last: 0};

    n_checks = 0;
    n_fail   = 0;
    n_out    = 0;
    tb_y     = 0;
    rst      = 1'b1;
    idle();
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_tvalid", {31'b0, m_if.tvalid}, 32'd0);
    check("rst_tlast",  {31'b0, m_if.tlast},  32'd0);
    check("rst_tdata",  m_if.tdata,           32'd0);
    check("rst_tstrb",  {28'b0, m_if.tstrb},  32'hF);
    check("rst_tready", {31'b0, s_if.tready}, 32'd1);
    @(posedge clk);
    #1;

    // Steady window with explicit one-cycle latency check.
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        check("pre_dump_tvalid", {31'b0, m_if.tvalid}, 32'd0);
        push_exp(100, 1'b0, ev);
      end
      send(100, 1'b0);
    end
    check("lat_tvalid", {31'b0, m_if.tvalid}, 32'd1);
    check("lat_tdata",  m_if.tdata, ev);
    check("lat_tstrb",  {28'b0, m_if.tstrb}, 32'hF);
    idle();
    drain(2);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        int  v;
        bit  l;
        v = (k == 0) ? vecs[i].first : vecs[i].rest;
        l = (k == vecs[i].n - 1) && vecs[i].last_on_final;
        if (k == vecs[i].n - 1) push_exp(vecs[i].mean, vecs[i].exp_last, ev);
        send(v, l);
      end
    end
    idle();
    drain(3);

    // Backpressure: first output stalled for 5 cycles.
    out_before  = n_out;
    bp_first    = '0;
    m_if.tready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 16; k++) begin
          if (k == 8)  push_exp(4, 1'b0, bp_first);
          if (k == 16) push_exp(12, 1'b0, ev);
          send(k, 1'b0);
        end
        idle();
      end
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!m_if.tvalid && g < 100);
        check("bp_seen_valid", {31'b0, m_if.tvalid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          check("bp_in_tready", {31'b0, s_if.tready}, 32'd0);
          check("bp_hold_data", m_if.tdata, bp_first);
        end
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
      end
    join
    drain(4);
    check("bp_out_count", 32'(n_out - out_before), 32'd2);

    // Reset mid-window discards the partial sum.
    for (int k = 0; k < 5; k++) send(500, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    tb_y = 0;
    check("midrst_tvalid", {31'b0, m_if.tvalid}, 32'd0);
    out_before = n_out;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) push_exp(10, 1'b0, ev);
      send(10, 1'b0);
    end
    idle();
    drain(3);
    check("midrst_out_count", 32'(n_out - out_before), 32'd1);

    // Two windows of 1600 from a cleared state.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    tb_y = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 7)  push_exp(1600, 1'b0, ev);
      if (k == 15) push_exp(1600, 1'b0, ev);
      send(1600, 1'b0);
    end
    idle();
    drain(5);
`ifdef FM_DEEMPH_EN
    check("deemph_second", ev, 32'd193);
`else
    check("plain_second", ev, 32'd1600);
`endif

    drain(5);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fm_audio_decimate.md
# fm_audio_decimate

Audio decimation stage placed directly downstream of the FM phase-difference demodulator. Consumes the demodulator's AXI-Stream output: one signed 16-bit discriminator sample per beat in `tdata[15:0]`. Sums each window of 2^DECIM_LOG2 accepted samples and emits their arithmetic-shifted mean as one AXI-Stream beat, reducing the IQ-rate stream to an audio-rate stream. An optional single-pole de-emphasis filter can be compiled in on the decimated output.

## Interface
- `C_S00_AXIS_TDATA_WIDTH`, 32, input stream width; only bits [15:0] are used.
- `C_M00_AXIS_TDATA_WIDTH`, 32, output stream width.
- `DECIM_LOG2`, 3, log2 of the decimation factor; legal range 1..8, so the factor is 2..256.
- `DEEMPH_SHIFT`, 4, de-emphasis coefficient exponent (alpha = 2^-DEEMPH_SHIFT); used only with `FM_DEEMPH_EN`.
- `s00_axis_aclk`, in, 1, the single clock for all logic.
- `s00_axis_areset`, in, 1, reset; synchronous, active-high.
- `s00_axis_tvalid`, in, 1, input beat valid.
- `s00_axis_tready`, out, 1, input ready.
- `s00_axis_tdata`, in, C_S00_AXIS_TDATA_WIDTH, [15:0] is a signed discriminator sample; upper bits are ignored.
- `s00_axis_tlast`, in, 1, end of packet; flushes the current window.
- `s00_axis_tstrb`, in, C_S00_AXIS_TDATA_WIDTH/8, ignored.
- `m00_axis_tvalid`, out, 1, output beat valid.
- `m00_axis_tready`, in, 1, downstream ready.
- `m00_axis_tdata`, out, C_M00_AXIS_TDATA_WIDTH, [15:0] is the signed audio sample; [31:16] is its sign extension.
- `m00_axis_tlast`, out, 1, set on a beat produced by a tlast flush.
- `m00_axis_tstrb`, out, C_M00_AXIS_TDATA_WIDTH/8, all ones whenever tvalid is high.

## Operation
- Accept condition: `acc_beat = s00_axis_tvalid && s00_axis_tready`.
- `s00_axis_tready = !m00_axis_tvalid || m00_axis_tready`. This is combinational and applies to every beat, not only dump beats.
- State:
  - `acc`: signed, 16+DECIM_LOG2 bits.
  - `cnt`: unsigned, DECIM_LOG2 bits.
  - One output register holding tdata, tlast and tvalid.
- On `acc_beat`, with `sum = acc + sext(x)` where `x = s00_axis_tdata[15:0]`:
  - Dump case, when `cnt == 2^DECIM_LOG2-1` or `s00_axis_tlast`:
    - Load the output register with `sum >>> DECIM_LOG2`. This is an arithmetic shift that floors toward -inf, then truncated to 16 bits; it cannot overflow.
    - Set `m00_axis_tvalid` to 1.
    - Set `m00_axis_tlast` to `s00_axis_tlast`.
    - Clear `acc` and `cnt` to 0.
  - Any other accepted beat: `acc <= sum`, `cnt <= cnt+1`. The output register is untouched.
- Partial windows flushed by tlast are not renormalised: the output is still the sum shifted by DECIM_LOG2.
- If the output register is valid and not taken (`m00_axis_tvalid && !m00_axis_tready`):
  - All output fields are held stable.
  - `s00_axis_tready` is 0, so no input is lost.
- When the output is taken and no dump occurs in the same cycle, `m00_axis_tvalid <= 0`.
- When the output is taken and a dump occurs in the same cycle, the register reloads with the new beat and tvalid stays 1.
- Reset (synchronous, active-high), applicable at any time including mid-window:
  - `acc`, `cnt` and the de-emphasis state go to 0.
  - `m00_axis_tvalid`, `m00_axis_tlast` and `m00_axis_tdata` go to 0.
  - `m00_axis_tstrb` goes to all ones.
  - A partial window in progress is discarded.

## Timing
- Latency: the output beat is valid in the cycle after the dump beat is accepted. With `FM_DEEMPH_EN` the latency is the same (no extra pipeline stage).
- Throughput:
  - With `m00_axis_tready` held high, one input is accepted per cycle.
  - One output is produced per 2^DECIM_LOG2 inputs, or earlier at tlast.
- A beat with tlast that also completes a full window produces a single output beat with tlast=1, not two beats.
- Counter wrap: `cnt` returns to 0 on every dump; there are no idle cycles between windows.

## Configuration
- Macro: `FM_DEEMPH_EN`.
- Defined:
  - State `y` is signed 16-bit, reset to 0.
  - On each dump: `d = m - y`, with `m` the decimated mean and `d` 17 bits signed.
  - Update: `y <= y + (d >>> DEEMPH_SHIFT)`.
  - The output tdata[15:0] carries this new `y`.
  - `y` is cleared only by reset; tlast does not clear it.
- Not defined:
  - The output is the decimated mean `m` directly.
  - No `y` register is synthesised and `DEEMPH_SHIFT` is unused.

## Test plan
All scenarios use DECIM_LOG2=3.

- **Steady window:** 8 samples of 100, tready high -> exactly one output, tdata=0x0000_0064, tlast=0, one cycle after the 8th accepted beat.
- **Sign and floor:** 8 samples of -3 -> 0xFFFF_FFFD. Samples {-1, then 7×0} -> 0xFFFF_FFFF (floor of -1/8 is -1).
- **Extremes:** 8×32767 -> 0x0000_7FFF. 8×-32768 -> 0xFFFF_8000. No wrap in either case.
- **tlast flush:** samples 80, 80, 80 with tlast on the 3rd -> output 30 (240>>>3) with tlast=1. The following 8×10 -> output 10 with tlast=0.
- **Backpressure:**
  - Stimulus: 16 back-to-back inputs of value k (k=1..16), with m00_axis_tready low for 5 cycles while the first output is valid.
  - Required: s00_axis_tready is 0 during the stall and the first output is held at 4 ((1+…+8)=36, 36>>>3).
  - Required: the second output is 12 ((9+…+16)=100, 100>>>3); exactly 2 outputs in total.
- **Reset mid-window and de-emphasis:**
  - 5 samples of 500, then a 1-cycle reset, then 8×10 -> single output 10.
  - With `FM_DEEMPH_EN` and DEEMPH_SHIFT=4: two windows of 8×1600 -> outputs 100, then 193.
